mux_ser8: RTL and testbench



---
 rtl/mux_ser8_pkg.sv | 22 ++
 rtl/mux_ser8_mux8_1.sv | 12 +
 rtl/mux_ser8.sv | 78 +++++++
 tb/tb_mux_ser8.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_ser8_pkg.sv
// Shared constants for the mux_ser8 parallel-to-serial sequencer.
// State encoding, widths and the select start/end values for either bit order.
package mux_ser8_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned WORD_W = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [SEL_W-1:0] SEL_LO = 3'd0;
  localparam logic [SEL_W-1:0] SEL_HI = 3'd7;

  function automatic logic [SEL_W-1:0] sel_start(input bit msb_first);
    return msb_first ? SEL_HI : SEL_LO;
  endfunction

  function automatic logic [SEL_W-1:0] sel_end(input bit msb_first);
    return msb_first ? SEL_LO : SEL_HI;
  endfunction

endpackage

// File: rtl/mux_ser8_mux8_1.sv
// Existing 8-to-1 bit selector driven by the serialiser's select counter.
module mux8_1
  import mux_ser8_pkg::*;
(
  input  logic [WORD_W-1:0] cin,
  input  logic [SEL_W-1:0]  sel,
  output logic              cout
);

  assign cout = cin[sel];

endmodule

// File: rtl/mux_ser8.sv
// Parallel-to-serial sequencer: accepts an 8-bit word via valid/ready and
// walks a 3-bit select across the 8:1 mux, with back-to-back words and pause.
module mux_ser8
  import mux_ser8_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              pause,
  output logic [SEL_W-1:0]  sel,
  output logic              sout,
  output logic              sout_valid,
  output logic              done
);

  localparam logic [SEL_W-1:0] SEL_START = sel_start(MSB_FIRST);
  localparam logic [SEL_W-1:0] SEL_END   = sel_end(MSB_FIRST);

  logic [0:0]        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [WORD_W-1:0] buf_q, buf_d;

  logic shifting;
  logic last_bit;
  logic accept;

  // Outputs depend only on registered state and pause, never on din/din_valid.
  always_comb begin
    shifting   = (state_q == ST_SHIFT) && !pause;
    last_bit   = shifting && (sel_q == SEL_END);
    din_ready  = (state_q == ST_IDLE) || last_bit;
    sout_valid = shifting;
    done       = last_bit;
    accept     = din_valid && din_ready;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    buf_d   = buf_q;
    if (accept) begin
      buf_d   = din;
      sel_d   = SEL_START;
      state_d = ST_SHIFT;
    end else if (last_bit) begin
      // Park sel at its start value so IDLE always presents it.
      sel_d   = SEL_START;
      state_d = ST_IDLE;
    end else if (shifting) begin
      sel_d = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_START;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      buf_q   <= buf_d;
    end
  end

  assign sel = sel_q;

  mux8_1 u_mux (
    .cin  (buf_q),
    .sel  (sel_q),
    .cout (sout)
  );

endmodule

// File: tb/tb_mux_ser8.sv
// Self-checking bench: LSB-first and MSB-first instances share stimulus and are
// compared every cycle against a word/bit-count model, plus directed literal checks.
module tb_mux_ser8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       pause;

  logic       r0, r1, o0, o1, v0, v1, d0, d1;
  logic [2:0] s0, s1;

  int tests = 0;
  int fails = 0;

  // Model: per instance, whether a word is in flight, how many bits of it have
  // been sent, and the last word captured.
  bit         busy[2];
  int         k[2];
  logic [7:0] word[2];

  logic       obs_v[2], obs_o[2], obs_d[2], obs_r[2];
  logic [2:0] obs_s[2];

  always #5 clk = ~clk;

  mux_ser8 #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(r0),
    .pause(pause), .sel(s0), .sout(o0), .sout_valid(v0), .done(d0)
  );

  mux_ser8 #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(r1),
    .pause(pause), .sel(s1), .sout(o1), .sout_valid(v1), .done(d1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int bit_index(input int m, input int kk);
    return (m == 1) ? 7 - kk : kk;
  endfunction

  function automatic bit exp_done(input int m);
    return busy[m] && !pause && (k[m] == 7);
  endfunction

  function automatic bit exp_ready(input int m);
    return !busy[m] || exp_done(m);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      busy[m] = 1'b0;
      k[m]    = 0;
      word[m] = 8'h00;
    end
  endtask

  task automatic compare_all();
    logic       a_r, a_o, a_v, a_d;
    logic [2:0] a_s;
    int         idx;
    for (int m = 0; m < 2; m++) begin
      if (m == 0) {a_r, a_s, a_o, a_v, a_d} = {r0, s0, o0, v0, d0};
      else        {a_r, a_s, a_o, a_v, a_d} = {r1, s1, o1, v1, d1};
      idx = busy[m] ? bit_index(m, k[m]) : bit_index(m, 0);
      check($sformatf("sel[%0d]", m), 32'(a_s), 32'(idx));
      check($sformatf("sout[%0d]", m), 32'(a_o), 32'(word[m][idx]));
      check($sformatf("sout_valid[%0d]", m), 32'(a_v), 32'(busy[m] && !pause));
      check($sformatf("done[%0d]", m), 32'(a_d), 32'(exp_done(m)));
      check($sformatf("din_ready[%0d]", m), 32'(a_r), 32'(exp_ready(m)));
      obs_v[m] = a_v; obs_o[m] = a_o; obs_d[m] = a_d; obs_r[m] = a_r; obs_s[m] = a_s;
    end
  endtask

  // Apply inputs for one cycle, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic p);
    bit         n_busy[2];
    int         n_k[2];
    logic [7:0] n_word[2];
    din_valid = v;
    din       = d;
    pause     = p;
    @(negedge clk);
    compare_all();
    for (int m = 0; m < 2; m++) begin
      n_busy[m] = busy[m];
      n_k[m]    = k[m];
      n_word[m] = word[m];
      if (v && exp_ready(m)) begin
        n_busy[m] = 1'b1;
        n_k[m]    = 0;
        n_word[m] = d;
      end else if (exp_done(m)) begin
        n_busy[m] = 1'b0;
        n_k[m]    = 0;
      end else if (busy[m] && !p) begin
        n_k[m] = k[m] + 1;
      end
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      busy[m] = n_busy[m];
      k[m]    = n_k[m];
      word[m] = n_word[m];
    end
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = 8'h00;
    pause     = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [7:0]  col0, col1;
    logic [15:0] vec;
    logic [7:0]  words[2];
    int          done_at0, done_at1, nvalid, nb;

    model_reset();
    do_reset(2);

    // Reset then idle.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    check("idle ready lsb", 32'(obs_r[0]), 32'd1);
    check("idle valid lsb", 32'(obs_v[0]), 32'd0);
    check("idle sel lsb", 32'(obs_s[0]), 32'd0);
    check("idle sel msb", 32'(obs_s[1]), 32'd7);

    // Single words through both bit orders.
    words[0] = 8'hA5;
    words[1] = 8'h81;
    for (int w = 0; w < 2; w++) begin
      step(1'b1, words[w], 1'b0);
      done_at0 = -1; done_at1 = -1;
      for (int i = 0; i < 8; i++) begin
        step(1'b0, 8'h00, 1'b0);
        col0[i]     = obs_o[0];
        col1[7 - i] = obs_o[1];
        if (obs_d[0]) done_at0 = i;
        if (obs_d[1]) done_at1 = i;
      end
      check("word bits lsb", 32'(col0), 32'(words[w]));
      check("word bits msb", 32'(col1), 32'(words[w]));
      check("done cycle lsb", 32'(done_at0), 32'd7);
      check("done cycle msb", 32'(done_at1), 32'd7);
      step(1'b0, 8'h00, 1'b0);
      check("after word ready", 32'(obs_r[0]), 32'd1);
      check("after word valid", 32'(obs_v[1]), 32'd0);
    end

    // Back-to-back FF then 00 with din_valid held until the second word is taken.
    step(1'b1, 8'hFF, 1'b0);
    nvalid = 0;
    vec    = '0;
    for (int i = 0; i < 17; i++) begin
      step(i < 8, 8'h00, 1'b0);
      if (obs_v[0]) nvalid++;
      if (i < 16) vec[i] = obs_o[0];
      if (i == 7) check("b2b ready on done", 32'(obs_r[0] && obs_d[0]), 32'd1);
    end
    check("b2b valid cycles", 32'(nvalid), 32'd16);
    check("b2b bits", 32'(vec), 32'h00FF);

    // Pause for 3 cycles at sel=4 on the LSB-first instance.
    step(1'b1, 8'h3C, 1'b0);
    col0 = '0; nb = 0; done_at0 = -1;
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 8'h00, (i >= 4 && i <= 6));
      if (i >= 4 && i <= 6) begin
        check("pause sel held", 32'(obs_s[0]), 32'd4);
        check("pause valid low", 32'(obs_v[0]), 32'd0);
      end
      if (obs_v[0]) begin
        col0[nb] = obs_o[0];
        nb++;
      end
      if (obs_d[0]) done_at0 = i;
    end
    check("pause bits", 32'(col0), 32'h3C);
    check("pause done cycle", 32'(done_at0), 32'd10);

    // Pause on the last bit suppresses done and din_ready.
    step(1'b1, 8'h96, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'h11, 1'b1);
      check("pause last sel", 32'(obs_s[0]), 32'd7);
      check("pause last done", 32'(obs_d[0]), 32'd0);
      check("pause last ready", 32'(obs_r[0]), 32'd0);
    end
    step(1'b0, 8'h00, 1'b0);
    check("unpause done", 32'(obs_d[0]), 32'd1);
    step(1'b0, 8'h00, 1'b0);

    // Asynchronous reset mid-word at sel=5.
    step(1'b1, 8'hC3, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);
    check("pre-reset sel", 32'(s0), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("async rst sel lsb", 32'(s0), 32'd0);
    check("async rst sel msb", 32'(s1), 32'd7);
    check("async rst valid", 32'({v0, v1}), 32'd0);
    check("async rst done", 32'({d0, d1}), 32'd0);
    check("async rst ready", 32'({r0, r1}), 32'd3);
    check("async rst sout", 32'({o0, o1}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    step(1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b0);
      col0[i] = obs_o[0];
      if (i == 0) check("restart sel", 32'(obs_s[0]), 32'd0);
    end
    check("restart bits", 32'(col0), 32'h5A);

    // Randomized traffic with occasional pauses and resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset(1);
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
